// File: rtl/mux_nto1_stream.sv
// rtl/mux_nto1_stream.sv - N-to-1 stream mux with manual or round-robin selection and a registered output.
// Optional registered even-parity output out_par is built when MUX_PARITY_EN is defined.
module mux_nto1_stream #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      auto_en,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef MUX_PARITY_EN
   ,
   output logic                      out_par
`endif
);

   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] c;
   logic             chosen;
   logic             ld;
   logic             xfer;
   logic [WIDTH-1:0] mux_data;
   int               scan_idx;

   assign ld = !out_valid || out_ready;

   // Channel choice: manual index (ignored when out of range) or the first
   // valid channel scanning upward from ptr with wrap-around.
   always_comb begin
      c        = '0;
      chosen   = 1'b0;
      scan_idx = 0;
      if (!auto_en) begin
         if (int'(sel) < CHANNELS) begin
            c      = sel;
            chosen = 1'b1;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            scan_idx = (int'(ptr) + i) % CHANNELS;
            if (!chosen && in_valid[scan_idx]) begin
               c      = SEL_W'(scan_idx);
               chosen = 1'b1;
            end
         end
      end
   end

   always_comb begin
      in_ready = '0;
      mux_data = '0;
      xfer     = 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (chosen && (int'(c) == k)) begin
            in_ready[k] = ld && !rst;
            mux_data    = in_data[k*WIDTH +: WIDTH];
            xfer        = ld && !rst && in_valid[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
`ifdef MUX_PARITY_EN
         out_par   <= 1'b0;
`endif
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= mux_data;
         out_ch    <= c;
`ifdef MUX_PARITY_EN
         out_par   <= ^mux_data;
`endif
         // Manual transfers leave the scan position where auto mode left it.
         if (auto_en) begin
            ptr <= (int'(c) == CHANNELS - 1) ? '0 : c + 1'b1;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
